dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: port 0 is the CPU load/store path (daddr/dwdata/dwe) and port 1 is the DMA/program-loader.
- Port 0 has fixed priority, with an aging counter that forces a port 1 grant after MAX_WAIT lost cycles.
- Memory read latency is 1 cycle. Reads and writes are fully pipelined, one access per cycle.
- The block tracks the owner of each outstanding read and returns the data to that requester.

---
 rtl/dmem_arbiter.sv | 93 +++++++++
 tb/tb_dmem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for a single-port data memory: port 0 (CPU) fixed priority, port 1 (DMA) aged.
// Latency: grant and memory strobe same cycle; read data returned one cycle after grant.
// Backpressure: a requester holds its request until gnt; port 1 is forced in after MAX_WAIT lost cycles.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [AW-1:0]     addr0,
    input  logic [DW-1:0]     wdata0,
    input  logic [DW/8-1:0]   we0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DW-1:0]     rdata0,
    input  logic              req1,
    input  logic [AW-1:0]     addr1,
    input  logic [DW-1:0]     wdata1,
    input  logic [DW/8-1:0]   we1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DW-1:0]     rdata1,
    output logic              mem_en,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_we,
    input  logic [DW-1:0]     mem_rdata
);

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [DW-1:0]   wdata;
        logic [DW/8-1:0] we;
    } mreq_t;

    typedef enum logic [1:0] {IDLE, RD0, RD1} rd_state_t;

    rd_state_t  state;
    logic [7:0] wait_cnt;
    logic       force1;
    mreq_t      mreq;

    assign force1 = (wait_cnt == 8'(MAX_WAIT));

    // Gating with reset keeps the memory quiet the instant reset asserts.
    assign gnt0 = reset & req0 & ~force1;
    assign gnt1 = reset & req1 & (~req0 | force1);

    always_comb begin
        mreq = '0;
        if (gnt0) begin
            mreq.addr  = addr0;
            mreq.wdata = wdata0;
            mreq.we    = we0;
        end else if (gnt1) begin
            mreq.addr  = addr1;
            mreq.wdata = wdata1;
            mreq.we    = we1;
        end
    end

    assign mem_en    = gnt0 | gnt1;
    assign mem_addr  = mreq.addr;
    assign mem_wdata = mreq.wdata;
    assign mem_we    = mreq.we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
        end else begin
            if (gnt0 && (we0 == '0))
                state <= RD0;
            else if (gnt1 && (we1 == '0))
                state <= RD1;
            else
                state <= IDLE;

            if (!req1 || gnt1)
                wait_cnt <= 8'd0;
            else if (wait_cnt < 8'(MAX_WAIT))
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign rvalid0 = (state == RD0);
    assign rvalid1 = (state == RD1);
    assign rdata0  = rvalid0 ? mem_rdata : '0;
    assign rdata1  = rvalid1 ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1-cycle-latency memory.
// Inputs are driven 1ns after the rising edge, outputs sampled 2ns after it.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [3:0]  we0, we1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        mem_en;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_we;

    logic [31:0] mem [0:255];
    int n_cmp = 0;
    int n_err = 0;
    logic prev0, prev1, e0, e1;

    dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we != 4'b0000) begin
                for (int b = 0; b < 4; b++)
                    if (mem_we[b]) mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= mem[mem_addr[9:2]];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 32'h11;
        mem[1] = 32'h22;
        mem[4] = 32'hDEADBEEF;
        mem_rdata = 32'h0;
        reset = 1'b0;
        req0 = 1'b1; addr0 = 32'h10; wdata0 = 32'h0; we0 = 4'h0;
        req1 = 1'b0; addr1 = 32'h0;  wdata1 = 32'h0; we1 = 4'h0;

        // Reset state: request present but masked by reset
        #2;
        chk("rst_gnt0", gnt0, 1'b0);
        chk("rst_gnt1", gnt1, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_rvalid0", rvalid0, 1'b0);
        chk("rst_rvalid1", rvalid1, 1'b0);
        chk("rst_rdata0", rdata0, 32'h0);
        req0 = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Port 0 read after reset
        step();
        req0 = 1'b1; addr0 = 32'h10; we0 = 4'h0;
        #1;
        chk("rd_gnt0", gnt0, 1'b1);
        chk("rd_gnt1", gnt1, 1'b0);
        chk("rd_mem_en", mem_en, 1'b1);
        chk("rd_mem_addr", mem_addr, 32'h10);
        chk("rd_mem_we", mem_we, 4'h0);
        step();
        req0 = 1'b0;
        #1;
        chk("rd_rvalid0", rvalid0, 1'b1);
        chk("rd_rdata0", rdata0, 32'hDEADBEEF);
        chk("rd_rvalid1", rvalid1, 1'b0);
        chk("rd_idle_en", mem_en, 1'b0);
        step();
        #1;
        chk("rd_rvalid0_drop", rvalid0, 1'b0);

        // Back-to-back write then read of the same word
        step();
        req0 = 1'b1; addr0 = 32'h20; wdata0 = 32'hA5A5A5A5; we0 = 4'hF;
        #1;
        chk("wr_gnt0", gnt0, 1'b1);
        chk("wr_mem_we", mem_we, 4'hF);
        chk("wr_mem_wdata", mem_wdata, 32'hA5A5A5A5);
        chk("wr_mem_addr", mem_addr, 32'h20);
        step();
        we0 = 4'h0;
        #1;
        chk("b2b_mem_en", mem_en, 1'b1);
        chk("b2b_mem_we", mem_we, 4'h0);
        chk("wr_no_rvalid", rvalid0, 1'b0);
        step();
        req0 = 1'b0;
        #1;
        chk("b2b_rvalid0", rvalid0, 1'b1);
        chk("b2b_rdata0", rdata0, 32'hA5A5A5A5);
        step();

        // Contention: port 1 forced in on cycle 4
        req0 = 1'b1; addr0 = 32'h0; we0 = 4'h0;
        req1 = 1'b1; addr1 = 32'h4; we1 = 4'h0;
        prev0 = 1'b0; prev1 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            e0 = (i != 4);
            e1 = (i == 4);
            #1;
            chk($sformatf("cont_gnt0_%0d", i), gnt0, e0);
            chk($sformatf("cont_gnt1_%0d", i), gnt1, e1);
            chk($sformatf("cont_rvalid0_%0d", i), rvalid0, prev0);
            chk($sformatf("cont_rvalid1_%0d", i), rvalid1, prev1);
            if (i == 5) chk("cont_rdata1", rdata1, 32'h22);
            prev0 = e0;
            prev1 = e1;
            step();
        end
        req0 = 1'b0; req1 = 1'b0;
        #1;
        chk("cont_tail_rvalid0", rvalid0, 1'b1);
        step();

        // Interleaved reads from both ports
        req0 = 1'b1; addr0 = 32'h0; we0 = 4'h0;
        #1;
        chk("il_gnt0", gnt0, 1'b1);
        step();
        req0 = 1'b0; req1 = 1'b1; addr1 = 32'h4; we1 = 4'h0;
        #1;
        chk("il_gnt1", gnt1, 1'b1);
        chk("il_rvalid0", rvalid0, 1'b1);
        chk("il_rdata0", rdata0, 32'h11);
        chk("il_rvalid1_a", rvalid1, 1'b0);
        step();
        req1 = 1'b0;
        #1;
        chk("il_rvalid1", rvalid1, 1'b1);
        chk("il_rdata1", rdata1, 32'h22);
        chk("il_rvalid0_b", rvalid0, 1'b0);
        chk("il_rdata0_mask", rdata0, 32'h0);
        step();

        // Lone port 1 keeps wait count at 0, proven by a full MAX_WAIT run once port 0 joins
        req1 = 1'b1; addr1 = 32'h4; we1 = 4'h0;
        for (int i = 0; i < 10; i++) begin
            req0 = (i >= 5);
            #1;
            chk($sformatf("lone_gnt1_%0d", i), gnt1, (i < 5) || (i == 9));
            chk($sformatf("lone_gnt0_%0d", i), gnt0, (i >= 5) && (i < 9));
            step();
        end

        // No requests: memory bus parked at zero
        req0 = 1'b0; req1 = 1'b0; addr0 = 32'h55; wdata0 = 32'h1234; we0 = 4'h3;
        #1;
        chk("idle_mem_en", mem_en, 1'b0);
        chk("idle_mem_addr", mem_addr, 32'h0);
        chk("idle_mem_wdata", mem_wdata, 32'h0);
        chk("idle_mem_we", mem_we, 4'h0);
        step();
        step();

        // Asynchronous reset half a cycle after a port 1 read grant
        req1 = 1'b1; addr1 = 32'h4; we1 = 4'h0; we0 = 4'h0;
        #1;
        chk("ar_gnt1", gnt1, 1'b1);
        step();
        #1;
        chk("ar_rvalid1_pre", rvalid1, 1'b1);
        chk("ar_gnt1_pre", gnt1, 1'b1);
        #2;
        reset = 1'b0;
        req0 = 1'b1;
        #1;
        chk("ar_rvalid1", rvalid1, 1'b0);
        chk("ar_rdata1", rdata1, 32'h0);
        chk("ar_gnt1", gnt1, 1'b0);
        chk("ar_gnt0", gnt0, 1'b0);
        chk("ar_mem_en", mem_en, 1'b0);
        chk("ar_mem_addr", mem_addr, 32'h0);
        step();
        #1;
        chk("ar_hold_rvalid1", rvalid1, 1'b0);
        chk("ar_hold_rvalid0", rvalid0, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step();
        #1;
        chk("ar_post_rvalid1", rvalid1, 1'b0);
        chk("ar_post_rvalid0", rvalid0, 1'b0);

        // First edge after release grants normally
        req0 = 1'b1; addr0 = 32'h10; we0 = 4'h0;
        #1;
        chk("post_gnt0", gnt0, 1'b1);
        step();
        req0 = 1'b0;
        #1;
        chk("post_rvalid0", rvalid0, 1'b1);
        chk("post_rdata0", rdata0, 32'hDEADBEEF);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
